// File: rtl/fdiv_result_packer.sv
// fdiv_result_packer: normalizes, RNE-rounds and packs Goldschmidt quotients into IEEE singles.
// Define FDIV_PACK_SUBNORMAL_EN for gradual underflow (default flush-to-zero); latency is 2 cycles in both builds.
module fdiv_result_packer #(
    parameter int EXP_W = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    in_sign,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic [1:0]              in_kind,
    input  logic                    in_invalid,
    input  logic                    in_dbz,
    input  logic                    q_ready,
    input  logic [31:0]             q,
    output logic                    busy,
    output logic                    out_valid,
    output logic [31:0]             result,
    output logic [4:0]              flags
);
    typedef enum logic [1:0] {IDLE, WAIT, ROUND, OUT} state_t;
    localparam logic [1:0] K_NORMAL = 2'd0, K_NAN = 2'd1, K_INF = 2'd2, K_ZERO = 2'd3;
    localparam logic signed [EXP_W:0] E_MAX = (EXP_W+1)'(255);

    state_t                r_state, w_next;
    logic                  r_sign, r_inv, r_dbz, r_g, r_s;
    logic [1:0]            r_kind;
    logic [22:0]           r_man;
    logic signed [EXP_W:0] r_e, w_e;
    logic [31:0]           r_result, w_res;
    logic [4:0]            r_flags, w_flg;
    logic [23:0]           w_sum;
    logic [30:0]           w_uf_res;
    logic                  w_up, w_ovf, w_unf, w_norm, w_uf_x;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && in_valid) begin
                r_sign <= in_sign;
                r_kind <= in_kind;
                r_inv  <= in_invalid;
                r_dbz  <= in_dbz;
                r_e    <= {in_exp[EXP_W-1], in_exp};
            end
            if (r_state == WAIT && q_ready) begin
                r_man <= q[31] ? q[30:8] : q[29:7];
                r_g   <= q[31] ? q[7] : q[6];
                r_s   <= q[31] ? |q[6:0] : |q[5:0];
                r_e   <= q[31] ? r_e : r_e - 1'b1;
            end
            if (r_state == ROUND) begin
                r_result <= w_res;
                r_flags  <= w_flg;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? (in_kind == K_NORMAL ? WAIT : ROUND) : IDLE;
            WAIT:    w_next = q_ready ? ROUND : WAIT;
            ROUND:   w_next = OUT;
            default: w_next = IDLE;
        endcase
    end

    assign w_up   = r_g & (r_s | r_man[0]);
    assign w_sum  = {1'b0, r_man} + {23'b0, w_up};
    assign w_e    = r_e + {{EXP_W{1'b0}}, w_sum[23]};
    assign w_ovf  = w_e >= E_MAX;
    assign w_unf  = w_e[EXP_W] | ~|w_e;
    assign w_norm = r_kind == K_NORMAL;

`ifdef FDIV_PACK_SUBNORMAL_EN
    // Subnormal path re-rounds the unrounded significand shifted right by 1-e.
    logic signed [EXP_W:0] w_shf;
    logic [4:0]            w_sh;
    logic [48:0]           w_sv;
    logic                  w_sg, w_ss;
    assign w_shf    = (EXP_W+1)'(1) - r_e;
    assign w_sh     = (w_shf > (EXP_W+1)'(25)) ? 5'd25 : w_shf[4:0];
    assign w_sv     = 49'({1'b1, r_man, r_g, 25'b0} >> w_sh);
    assign w_sg     = w_sv[25];
    assign w_ss     = r_s | (|w_sv[24:0]);
    assign w_uf_res = {8'h00, w_sv[48:26]} + {30'b0, w_sg & (w_ss | w_sv[26])};
    assign w_uf_x   = w_sg | w_ss;
`else
    assign w_uf_res = '0;
    assign w_uf_x   = 1'b1;
`endif

    assign w_res = r_kind == K_NAN  ? 32'h7FC00000 :
                   r_kind == K_INF  ? {r_sign, 8'hFF, 23'h0} :
                   r_kind == K_ZERO ? {r_sign, 31'h0} :
                   w_ovf            ? {r_sign, 8'hFF, 23'h0} :
                   w_unf            ? {r_sign, w_uf_res} :
                                      {r_sign, w_e[7:0], w_sum[22:0]};
    assign w_flg = {r_inv, r_dbz, w_norm & w_ovf, w_norm & ~w_ovf & w_unf & w_uf_x,
                    w_norm & (w_ovf | (w_unf ? w_uf_x : (r_g | r_s)))};

    assign busy      = r_state != IDLE;
    assign out_valid = r_state == OUT;
    assign result    = r_result;
    assign flags     = r_flags;
endmodule

// File: tb/tb_fdiv_result_packer.sv
// tb_fdiv_result_packer: directed and random checks of fdiv_result_packer against an arithmetic model.
module tb_fdiv_result_packer;
    logic              clock = 0, reset = 1, in_valid = 0, in_sign = 0, in_invalid = 0, in_dbz = 0, q_ready = 0;
    logic signed [9:0] in_exp = '0;
    logic [1:0]        in_kind = '0;
    logic [31:0]       q = '0, result;
    logic              busy, out_valid;
    logic [4:0]        flags;
    int                n_chk = 0, n_pass = 0;

    fdiv_result_packer dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_sign(in_sign), .in_exp(in_exp),
        .in_kind(in_kind), .in_invalid(in_invalid), .in_dbz(in_dbz), .q_ready(q_ready), .q(q),
        .busy(busy), .out_valid(out_valid), .result(result), .flags(flags)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) $display("FAIL %s got=%h want=%h", tag, got, want);
        else n_pass++;
    endtask

    // Exact integer view of the quotient: rounding is done on remainders, not bit fields.
    function automatic logic [36:0] model(input bit sg, input int ex, input logic [1:0] kd,
                                          input bit inv, input bit dbz, input logic [31:0] qq);
        longint qn, m, rem, q2, r2, half;
        int     e, e0, k;
        bit     up, x;
        if (kd == 2'd1) return {inv, dbz, 3'b000, 32'h7FC00000};
        if (kd == 2'd2) return {inv, dbz, 3'b000, sg, 8'hFF, 23'h0};
        if (kd == 2'd3) return {inv, dbz, 3'b000, sg, 31'h0};
        qn = longint'(qq);
        e  = ex;
        if (!qq[31]) begin
            qn = qn * 2;
            e  = e - 1;
        end
        e0  = e;
        m   = qn >> 8;
        rem = qn % 256;
        up  = (rem > 128) || (rem == 128 && m[0]);
        m   = m + longint'(up);
        if (m == 64'd16777216) begin
            m = m / 2;
            e++;
        end
        if (e >= 255) return {inv, dbz, 3'b101, sg, 8'hFF, 23'h0};
        if (e <= 0) begin
`ifdef FDIV_PACK_SUBNORMAL_EN
            k    = 9 - e0;
            if (k > 40) k = 40;
            q2   = qn >> k;
            r2   = qn - (q2 << k);
            half = 64'd1 << (k - 1);
            up   = (r2 > half) || (r2 == half && q2[0]);
            x    = r2 != 0;
            q2   = q2 + longint'(up);
            return {inv, dbz, 1'b0, x, x, sg, q2[30:0]};
`else
            return {inv, dbz, 3'b011, sg, 31'h0};
`endif
        end
        return {inv, dbz, 2'b00, rem != 0, sg, e[7:0], m[22:0]};
    endfunction

    task automatic finish_q(input logic [31:0] qq, input logic [36:0] want, input string tag);
        q_ready = 1;
        q = qq;
        @(negedge clock);
        q_ready = 0;
        check({tag, "_ov_round"}, out_valid, 0);
        @(negedge clock);
        check({tag, "_ov"}, out_valid, 1);
        check({tag, "_res"}, result, want[31:0]);
        check({tag, "_flg"}, flags, want[36:32]);
    endtask

    task automatic do_op(input bit sg, input int ex, input logic [1:0] kd, input bit inv, input bit dbz,
                         input logic [31:0] qq, input int dly, input logic [36:0] want, input string tag);
        @(negedge clock);
        in_valid = 1; in_sign = sg; in_exp = ex[9:0]; in_kind = kd; in_invalid = inv; in_dbz = dbz;
        @(negedge clock);
        in_valid = 0;
        if (kd == 2'd0) begin
            check({tag, "_busy"}, busy, 1);
            repeat (dly) @(negedge clock);
            finish_q(qq, want, tag);
        end else begin
            check({tag, "_ov_round"}, out_valid, 0);
            @(negedge clock);
            check({tag, "_ov"}, out_valid, 1);
            check({tag, "_res"}, result, want[31:0]);
            check({tag, "_flg"}, flags, want[36:32]);
        end
    endtask

    initial begin
        logic [31:0] qq;
        int          ex;
        logic [1:0]  kd;
        bit          sg, inv, dbz;
        repeat (2) @(negedge clock);
        reset = 0;
        check("rst_busy", busy, 0);
        check("rst_ov", out_valid, 0);
        check("rst_res", result, 0);
        check("rst_flg", flags, 0);

        do_op(0, 127, 0, 0, 0, 32'hC0000000, 0, {5'b00000, 32'h3FC00000}, "t1");
        check("t1_hold", result, 32'h3FC00000);
        do_op(0, 127, 0, 0, 0, 32'h55555555, 2, {5'b00001, 32'h3F2AAAAB}, "t2");
        do_op(0, 127, 0, 0, 0, 32'hFFFFFFFF, 1, {5'b00001, 32'h40000000}, "t3");
        do_op(0, 255, 0, 0, 0, 32'hC0000000, 0, {5'b00101, 32'h7F800000}, "t4_ovf");
`ifdef FDIV_PACK_SUBNORMAL_EN
        do_op(1, 0, 0, 0, 0, 32'hC0000000, 0, {5'b00000, 32'h80600000}, "t4_unf");
`else
        do_op(1, 0, 0, 0, 0, 32'hC0000000, 0, {5'b00011, 32'h80000000}, "t4_unf");
`endif
        do_op(1, 0, 1, 1, 0, 32'h0, 0, {5'b10000, 32'h7FC00000}, "t5_nan");
        do_op(1, 0, 2, 0, 1, 32'h0, 0, {5'b01000, 32'hFF800000}, "t5_inf");
        do_op(1, 0, 3, 0, 0, 32'h0, 0, {5'b00000, 32'h80000000}, "t5_zero");

        // in_valid while waiting must not replace the captured op
        @(negedge clock);
        in_valid = 1; in_sign = 0; in_exp = 127; in_kind = 0;
        @(negedge clock);
        in_kind = 1; in_sign = 1;
        @(negedge clock);
        in_valid = 0;
        check("t6_ign_busy", busy, 1);
        finish_q(32'hC0000000, {5'b00000, 32'h3FC00000}, "t6_ign");

        // stray q_ready while idle
        @(negedge clock);
        q_ready = 1;
        q = 32'hC0000000;
        @(negedge clock);
        q_ready = 0;
        for (int i = 0; i < 3; i++) begin
            check("t6_stray_ov", out_valid, 0);
            check("t6_stray_busy", busy, 0);
            @(negedge clock);
        end

        // q_ready coincident with in_valid is dropped; op still waits
        in_valid = 1; in_sign = 0; in_exp = 127; in_kind = 0; q_ready = 1; q = 32'h80000000;
        @(negedge clock);
        in_valid = 0; q_ready = 0;
        for (int i = 0; i < 3; i++) begin
            check("t6_coin_busy", busy, 1);
            check("t6_coin_ov", out_valid, 0);
            @(negedge clock);
        end
        finish_q(32'hC0000000, {5'b00000, 32'h3FC00000}, "t6_coin");

        // reset while waiting aborts; later q_ready ignored
        @(negedge clock);
        in_valid = 1; in_exp = 127; in_kind = 0;
        @(negedge clock);
        in_valid = 0;
        reset = 1;
        @(negedge clock);
        reset = 0;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_res", result, 0);
        q_ready = 1;
        q = 32'hC0000000;
        @(negedge clock);
        q_ready = 0;
        for (int i = 0; i < 3; i++) begin
            check("t6_rst_ov", out_valid, 0);
            check("t6_rst_busy2", busy, 0);
            @(negedge clock);
        end

        for (int n = 0; n < 60; n++) begin
            qq = $urandom;
            if (!qq[31]) qq[30] = 1'b1;
            if ($urandom_range(0, 3) == 0) qq[7:0] = 8'h80;
            if ($urandom_range(0, 3) == 0) qq[6:0] = 7'h0;
            ex  = int'($urandom_range(0, 320)) - 40;
            kd  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            sg  = 1'($urandom);
            inv = (kd != 0) && ($urandom_range(0, 1) == 1);
            dbz = (kd == 2) && ($urandom_range(0, 1) == 1);
            do_op(sg, ex, kd, inv, dbz, qq, int'($urandom_range(0, 3)), model(sg, ex, kd, inv, dbz, qq), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
